mmu_sequencer: RTL
==================

// Module: mmu_sequencer
// PURPOSE
//   Sequences one C = A x W product on the 2x2 systolic mmu (8-bit PEs, weight-stationary).
//   On start: snapshots operand matrices A (2x2) and W (2x2), then loads W into the PEs.
//   Streams A row-by-row with a one-cycle skew on the second lane, and captures the
//   skewed acc_out1/acc_out2 results into a 2x2 result register set. Sits between the
//   host/register bank and the mmu instance; the mmu is driven only by this block.
// PARAMETERS
//   DATA_W    8  operand/result width; must match mmu datapath width
//   CAP0_LAT  2  feed-cycle offset at which column-0 result of row i appears (i+CAP0_LAT)
//   CAP1_LAT  3  feed-cycle offset at which column-1 result of row i appears (i+CAP1_LAT)
// PORTS
//   clk              in   1       system clock, rising edge
//   reset            in   1       asynchronous, active-low reset
//   start            in   1       request one product; sampled only in IDLE
//   a00,a01,a10,a11  in   DATA_W  activation matrix A[row][col]
//   w00,w01,w10,w11  in   DATA_W  weight matrix W[row][col]
//   mmu_acc1         in   DATA_W  from mmu acc_out1 (column 0)
//   mmu_acc2         in   DATA_W  from mmu acc_out2 (column 1)
//   mmu_load_weight  out  1       to mmu load_weight
//   mmu_valid        out  1       to mmu valid
//   mmu_a_in1        out  DATA_W  to mmu a_in1 (A column 0 lane)
//   mmu_a_in2        out  DATA_W  to mmu a_in2 (A column 1 lane)
//   mmu_weight1..4   out  DATA_W  to mmu weight1..4 = W00, W10, W01, W11
//   c00,c01,c10,c11  out  DATA_W  result matrix C[row][col], registered
//   busy             out  1       high in LOAD/FEED/DRAIN/DONE
//   done             out  1       one-cycle pulse; C valid from this cycle
// BEHAVIOUR
//   Reset (async, reset=0): state=IDLE, cyc=0, all outputs and operand/result regs = 0.
//   Reset asserted mid-operation aborts immediately; no partial results are retained.
//   FSM: IDLE -start-> LOAD -> FEED (cyc 0..2) -> DRAIN (cyc 3..4) -> DONE -> IDLE.
//   IDLE: start=1 latches A,W into internal regs; all mmu_* outputs 0. start=0: stay.
//   LOAD (1 cycle): mmu_load_weight=1, mmu_weight1..4 driven from latched W; mmu_valid=0.
//   mmu_weight1..4 hold latched W from LOAD until the next start; 0 after reset.
//   FEED/DRAIN: mmu_valid=1, mmu_load_weight=0; cyc counts 0..4, cleared on leaving DRAIN.
//     cyc0: a_in1=A00 a_in2=0 | cyc1: a_in1=A10 a_in2=A01 | cyc2: a_in1=0 a_in2=A11
//     cyc3,4: a_in1=a_in2=0.
//   Capture (registered at end of cycle): C[i][0]<=mmu_acc1 when cyc==i+CAP0_LAT;
//     C[i][1]<=mmu_acc2 when cyc==i+CAP1_LAT. Defaults capture c00@2,c10@3,c01@3,c11@4.
//   DRAIN exits after cyc==4 (cyc_max = 1+CAP1_LAT).
//   DONE (1 cycle): done=1, busy=1, mmu_* data = 0. c** hold until next capture.
//   Latency: start sampled in cycle 0 -> LOAD 1, FEED 2-4, DRAIN 5-6, done in cycle 7.
//   start outside IDLE (incl. DONE) is ignored, not queued; A/W input changes after the
//     start cycle have no effect on the running product.
//   Arithmetic: performed in mmu; C[i][j] = (A[i][0]*W[0][j] + A[i][1]*W[1][j]) mod 2^DATA_W.
//     Sequencer applies no saturation or sign handling.
// TESTING
//   1 Reset: reset=0 mid-FEED -> next edge-independent: IDLE, busy=0, done=0, c**=0, mmu_*=0.
//   2 A=[[1,2],[3,4]], W=[[5,6],[7,8]], start 1 cycle -> done at cycle 7; C=[[19,22],[43,50]].
//   3 Waveform check on test 2: load_weight only cycle 1; a_in1 = 1,3,0; a_in2 = 0,2,4 in cycles 2-4.
//   4 Wrap: A=[[15,0],[0,0]], W=[[20,0],[0,0]] -> c00=44 (300 mod 256), others 0.
//   5 start held high continuously -> back-to-back ops, done every 8 cycles; start in DONE ignored.
//   6 Change A/W in cycle 1 after start -> results equal those of the values latched at start.

Source files
------------

// File: rtl/mmu_sequencer.sv
// -----------------------------------------------------------------------------
// mmu_sequencer
//   Runs one C = A x W product on the 2x2 weight-stationary systolic mmu.
//   On start the operand matrices are snapshotted, W is loaded into the PEs,
//   A is streamed row by row (second lane skewed by one cycle) and the skewed
//   column results are captured into a registered 2x2 result set.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   start                      request one product, sampled only in IDLE
//   a00..a11, w00..w11         operand matrices A[row][col], W[row][col]
//   mmu_acc1, mmu_acc2         mmu column-0 / column-1 accumulator outputs
//   mmu_load_weight, mmu_valid mmu control
//   mmu_a_in1, mmu_a_in2       A lanes (column 0 / column 1 of A)
//   mmu_weight1..4             W00, W10, W01, W11
//   c00..c11                   registered result matrix
//   busy                       high in LOAD/FEED/DRAIN/DONE
//   done                       one-cycle pulse, C valid from this cycle
// -----------------------------------------------------------------------------
module mmu_sequencer #(
    parameter int DATA_W   = 8,
    parameter int CAP0_LAT = 2,
    parameter int CAP1_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] w00,
    input  logic [DATA_W-1:0] w01,
    input  logic [DATA_W-1:0] w10,
    input  logic [DATA_W-1:0] w11,
    input  logic [DATA_W-1:0] mmu_acc1,
    input  logic [DATA_W-1:0] mmu_acc2,
    output logic              mmu_load_weight,
    output logic              mmu_valid,
    output logic [DATA_W-1:0] mmu_a_in1,
    output logic [DATA_W-1:0] mmu_a_in2,
    output logic [DATA_W-1:0] mmu_weight1,
    output logic [DATA_W-1:0] mmu_weight2,
    output logic [DATA_W-1:0] mmu_weight3,
    output logic [DATA_W-1:0] mmu_weight4,
    output logic [DATA_W-1:0] c00,
    output logic [DATA_W-1:0] c01,
    output logic [DATA_W-1:0] c10,
    output logic [DATA_W-1:0] c11,
    output logic              busy,
    output logic              done
);

    // Last streaming cycle: the column-1 result of the last row lands here.
    localparam int CYC_MAX   = 1 + CAP1_LAT;
    // Last cycle carrying A data (row 1 on the skewed lane).
    localparam int FEED_LAST = 2;
    localparam int CYC_W     = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic [CYC_W-1:0] cyc;

    // [row][col] operand snapshots and results
    logic [1:0][1:0][DATA_W-1:0] a_q, w_q, c_q;

    logic streaming;
    assign streaming = (state == S_FEED) || (state == S_DRAIN);

    // ------------------------------------------------------------------
    // State, counter, snapshots and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cyc   <= '0;
            a_q   <= '0;
            w_q   <= '0;
            c_q   <= '0;
        end else begin
            state <= state_nxt;

            // Snapshot only on an accepted start; later input changes are ignored.
            if (state == S_IDLE && start) begin
                a_q <= {a11, a10, a01, a00};
                w_q <= {w11, w10, w01, w00};
            end

            if (streaming)
                cyc <= (state == S_DRAIN && cyc == CYC_W'(CYC_MAX)) ? '0 : cyc + 1'b1;
            else
                cyc <= '0;

            // Row i's column results emerge from the array at fixed skewed offsets.
            if (streaming) begin
                for (int i = 0; i < 2; i++) begin
                    if (cyc == CYC_W'(i + CAP0_LAT)) c_q[i][0] <= mmu_acc1;
                    if (cyc == CYC_W'(i + CAP1_LAT)) c_q[i][1] <= mmu_acc2;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and mmu control/data
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        mmu_load_weight = 1'b0;
        mmu_valid       = 1'b0;
        mmu_a_in1       = '0;
        mmu_a_in2       = '0;
        done            = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                mmu_load_weight = 1'b1;
                state_nxt       = S_FEED;
            end
            S_FEED: begin
                mmu_valid = 1'b1;
                // Lane 2 trails lane 1 by one cycle so row data meet in the array.
                case (cyc)
                    CYC_W'(0): mmu_a_in1 = a_q[0][0];
                    CYC_W'(1): begin
                        mmu_a_in1 = a_q[1][0];
                        mmu_a_in2 = a_q[0][1];
                    end
                    CYC_W'(2): mmu_a_in2 = a_q[1][1];
                    default: ;
                endcase
                if (cyc == CYC_W'(FEED_LAST)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                mmu_valid = 1'b1;
                if (cyc == CYC_W'(CYC_MAX)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Weights stay on the bus from LOAD until the next accepted start.
    assign mmu_weight1 = w_q[0][0];
    assign mmu_weight2 = w_q[1][0];
    assign mmu_weight3 = w_q[0][1];
    assign mmu_weight4 = w_q[1][1];

    assign c00 = c_q[0][0];
    assign c01 = c_q[0][1];
    assign c10 = c_q[1][0];
    assign c11 = c_q[1][1];

endmodule
